// File: rtl/pc_update_unit_if.sv
// Connection bundle between the PC stage and its decode/memory/flow-select neighbours.
// The slave side is the PC unit; the master side is whatever drives decode and stall.
interface pc_update_unit_if #(
  parameter int WIDTH    = 32,
  parameter int OFFSET_W = 8
);
  logic                BUSYWAIT;
  logic                JUMP;
  logic                BRANCH;
  logic                ZERO;
  logic [OFFSET_W-1:0] OFFSET;
  logic [WIDTH-1:0]    PC;
  logic [WIDTH-1:0]    PC_PLUS4;
  logic [WIDTH-1:0]    TARGET;
  logic                FLOW_SEL;
  logic                REDIRECT_PENDING;

  modport slave (
    input  BUSYWAIT, JUMP, BRANCH, ZERO, OFFSET,
    output PC, PC_PLUS4, TARGET, FLOW_SEL, REDIRECT_PENDING
  );

  modport master (
    output BUSYWAIT, JUMP, BRANCH, ZERO, OFFSET,
    input  PC, PC_PLUS4, TARGET, FLOW_SEL, REDIRECT_PENDING
  );
endinterface

// File: rtl/pc_update_unit.sv
// Architectural PC register with PC+4 / PC-relative target generation and flow select.
// A redirect decided while memory stalls is latched and applied on the first unstalled edge.
module pc_update_unit #(
  parameter int                WIDTH    = 32,
  parameter int                OFFSET_W = 8,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  pc_update_unit_if.slave  bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, HOLD_REDIR} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pend_tgt;
  logic             pend;

  logic [WIDTH-1:0] pc_plus4, target, off_sext, next_pc;
  logic             taken;

  // output-comb controls
  logic             pc_we, pend_set, pend_clr;
  logic [WIDTH-1:0] pc_d;

  assign off_sext = {{(WIDTH-OFFSET_W){bus.OFFSET[OFFSET_W-1]}}, bus.OFFSET};
  assign pc_plus4 = pc + WIDTH'(4);
  assign target   = pc_plus4 + (off_sext << 2);
  assign taken    = bus.JUMP | (bus.BRANCH & bus.ZERO);
  assign next_pc  = taken ? target : pc_plus4;

  assign bus.PC               = pc;
  assign bus.PC_PLUS4         = pc_plus4;
  assign bus.TARGET           = target;
  assign bus.FLOW_SEL         = taken;
  assign bus.REDIRECT_PENDING = pend;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state <= state_nxt;
      if (pc_we)    pc       <= pc_d;
      if (pend_set) pend_tgt <= target;
      if (pend_set)      pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:       if (!bus.BUSYWAIT) state_nxt = RUN;
      RUN, HOLD:  if (!bus.BUSYWAIT) state_nxt = RUN;
                  else if (taken)    state_nxt = HOLD_REDIR;
                  else               state_nxt = HOLD;
      HOLD_REDIR: if (!bus.BUSYWAIT) state_nxt = RUN;
      default:    state_nxt = BOOT;
    endcase
  end

  // HOLD_REDIR ignores the live flow select: the first captured target wins.
  always_comb begin
    pc_we    = 1'b0;
    pc_d     = next_pc;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state)
      RUN, HOLD: begin
        pc_we    = !bus.BUSYWAIT;
        pend_set = bus.BUSYWAIT & taken;
      end
      HOLD_REDIR: begin
        pc_we    = !bus.BUSYWAIT;
        pc_d     = pend_tgt;
        pend_clr = !bus.BUSYWAIT;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed-vector bench for pc_update_unit with a cycle-tagged scoreboard.
module tb_pc_update_unit;
  localparam int WIDTH = 32;
  localparam int OFFSET_W = 8;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        fl;
    logic        pd;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;
  exp_t q[$];

  pc_update_unit_if #(.WIDTH(WIDTH), .OFFSET_W(OFFSET_W)) bus ();

  pc_update_unit #(.WIDTH(WIDTH), .OFFSET_W(OFFSET_W), .RESET_PC(32'h0)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic drive(input bit bz, input bit j, input bit b, input bit z, input logic [7:0] off);
    bus.BUSYWAIT = bz;
    bus.JUMP     = j;
    bus.BRANCH   = b;
    bus.ZERO     = z;
    bus.OFFSET   = off;
  endtask

  task automatic push(input string nm, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic fl, input logic pd);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.pc = pc; e.tgt = tgt; e.fl = fl; e.pd = pd;
    q.push_back(e);
  endtask

  // Past an edge: drive the inputs for the next edge, expect the state this edge produced.
  task automatic step(input string nm, input bit bz, input bit j, input bit b, input bit z,
                      input logic [7:0] off, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic fl, input logic pd);
    @(posedge CLK); #1;
    drive(bz, j, b, z, off);
    push(nm, pc, tgt, fl, pd);
  endtask

  // Monitor: compares every expectation tagged for the current cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (e.cyc != cyc) begin
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
        end else if (bus.PC !== e.pc || bus.PC_PLUS4 !== e.pc + 32'd4 || bus.TARGET !== e.tgt ||
                     bus.FLOW_SEL !== e.fl || bus.REDIRECT_PENDING !== e.pd) begin
          n_bad++;
          $display("FAIL %s: got pc=%h p4=%h tgt=%h sel=%b pend=%b, want pc=%h p4=%h tgt=%h sel=%b pend=%b",
                   e.name, bus.PC, bus.PC_PLUS4, bus.TARGET, bus.FLOW_SEL, bus.REDIRECT_PENDING,
                   e.pc, e.pc + 32'd4, e.tgt, e.fl, e.pd);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: stimulus did not complete, got timeout, want completion");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    RESET = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    @(posedge CLK); #1;
    push("reset", 32'h0, 32'h4, 1'b0, 1'b0);
    @(negedge CLK); #2;
    RESET = 1'b1;

    step("boot",      0,0,0,0,8'h00, 32'h00, 32'h04, 0,0);
    step("run4",      0,0,0,0,8'h00, 32'h04, 32'h08, 0,0);
    step("beq_taken", 0,0,1,1,8'h02, 32'h08, 32'h14, 1,0);
    step("jmp_back",  0,1,0,0,8'hFC, 32'h14, 32'h08, 1,0);
    step("beq_not",   0,0,1,0,8'h02, 32'h08, 32'h14, 0,0);
    step("jmp_fwd",   0,1,0,0,8'h04, 32'h0C, 32'h20, 1,0);
    step("jmp_neg",   0,1,0,0,8'hFC, 32'h20, 32'h14, 1,0);
    step("jb_offff",  0,1,1,0,8'hFF, 32'h14, 32'h14, 1,0);
    step("to_wrap",   0,1,0,0,8'hF9, 32'h14, 32'hFFFFFFFC, 1,0);
    step("wrap",      0,0,0,0,8'h00, 32'hFFFFFFFC, 32'h0, 0,0);
    step("to_10",     0,1,0,0,8'h03, 32'h00, 32'h10, 1,0);
    step("stall_jmp", 1,1,0,0,8'h03, 32'h10, 32'h20, 1,0);
    step("stall_chg", 1,1,0,0,8'h05, 32'h10, 32'h28, 1,1);
    step("stall_3",   1,0,0,0,8'h00, 32'h10, 32'h14, 0,1);
    step("stall_end", 0,1,0,0,8'h05, 32'h10, 32'h28, 1,1);
    step("redir",     0,1,0,0,8'hFB, 32'h20, 32'h10, 1,0);
    step("hold_1",    1,0,0,0,8'h00, 32'h10, 32'h14, 0,0);
    step("hold_2",    1,0,0,0,8'h00, 32'h10, 32'h14, 0,0);
    step("hold_end",  0,0,0,0,8'h00, 32'h10, 32'h14, 0,0);
    step("after_hold",1,0,0,0,8'h00, 32'h14, 32'h18, 0,0);
    step("hold_cap",  1,1,0,0,8'h0A, 32'h14, 32'h40, 1,0);
    step("hold_redir",0,0,0,0,8'h00, 32'h14, 32'h18, 0,1);
    step("pend40",    1,1,0,0,8'h01, 32'h40, 32'h48, 1,0);
    step("pend40b",   1,1,0,0,8'h01, 32'h40, 32'h48, 1,1);

    // Reset between edges with a redirect pending.
    @(posedge CLK); #2;
    RESET = 1'b0;
    push("rst_mid", 32'h0, 32'h8, 1'b1, 1'b0);
    @(negedge CLK); #2;
    drive(1, 0, 0, 0, 8'h00);
    RESET = 1'b1;

    step("boot_busy", 0,0,0,0,8'h00, 32'h00, 32'h04, 0,0);
    step("boot_rel",  0,0,0,0,8'h00, 32'h00, 32'h04, 0,0);
    step("rerun",     0,0,0,0,8'h00, 32'h04, 32'h08, 0,0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
